// File: rtl/sensor_spi_pkg.sv
// Shared layout of the 16-byte sensor packet (MSB-first on the wire) and the reader FSM states.
package sensor_spi_pkg;

  localparam int PACKET_SIZE = 16;
  localparam int PACKET_BITS = PACKET_SIZE * 8;
  localparam logic [7:0] HEADER_BYTE = 8'hAA;

  localparam int HDR_OFS    = 0;
  localparam int QUAT_W_OFS = 1;
  localparam int QUAT_X_OFS = 3;
  localparam int QUAT_Y_OFS = 5;
  localparam int QUAT_Z_OFS = 7;
  localparam int GYRO_X_OFS = 9;
  localparam int GYRO_Y_OFS = 11;
  localparam int GYRO_Z_OFS = 13;
  localparam int FLAGS_OFS  = 15;

  localparam int FLAG_QUAT_VALID = 0;
  localparam int FLAG_GYRO_VALID = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_LOW
  } spi_rd_state_t;

  // Byte 0 is the first byte on the wire, so it sits in the top bits of the packet vector.
  function automatic logic [7:0] packet_byte(input logic [PACKET_BITS-1:0] pkt, input int ofs);
    return 8'(pkt >> (PACKET_BITS - 8 * (ofs + 1)));
  endfunction

  function automatic logic [15:0] packet_word(input logic [PACKET_BITS-1:0] pkt, input int ofs);
    return {packet_byte(pkt, ofs), packet_byte(pkt, ofs + 1)};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// CPOL=0 SPI clock generator: toggles sck every CLK_DIV cycles while run is high, parks low otherwise.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic tick,
  output logic rise_stb,
  output logic fall_stb
);

  logic [7:0] div_cnt_reg;

  // tick does not depend on run, so the master may use it to decide run without a loop
  assign tick     = (div_cnt_reg == 8'(CLK_DIV - 1));
  assign rise_stb = run && tick && !sck;
  assign fall_stb = run && tick && sck;

  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      div_cnt_reg <= 8'd0;
      sck         <= 1'b0;
    end else if (tick) begin
      div_cnt_reg <= 8'd0;
      sck         <= !sck;
    end else begin
      div_cnt_reg <= div_cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/sensor_packet_spi_master.sv
// Mode-0 SPI reader for the 16-byte sensor packet: waits for done, shifts 128 bits,
// acknowledges with load, then validates the header and unpacks the fields.
module sensor_packet_spi_master
  import sensor_spi_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int LOAD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               done,
  output logic               load,
  output logic               sck,
  output logic               sdo,
  input  logic               sdi,
  output logic signed [15:0] quat_w,
  output logic signed [15:0] quat_x,
  output logic signed [15:0] quat_y,
  output logic signed [15:0] quat_z,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               quat_valid,
  output logic               gyro_valid,
  output logic               pkt_valid,
  output logic               hdr_err,
  output logic               busy,
  output logic [15:0]        pkt_count,
  output logic [15:0]        err_count
);

  localparam int NUM_WORDS = 7;
  localparam int WORD_OFS [NUM_WORDS] = '{QUAT_W_OFS, QUAT_X_OFS, QUAT_Y_OFS, QUAT_Z_OFS,
                                          GYRO_X_OFS, GYRO_Y_OFS, GYRO_Z_OFS};

  spi_rd_state_t state_reg, state_next;

  logic                         done_meta_reg, done_sync_reg;
  logic [PACKET_BITS-1:0]       shift_reg;
  logic [6:0]                   bit_cnt_reg;
  logic                         last_low_reg;
  logic [15:0]                  ack_cnt_reg;
  logic                         load_reg, pkt_valid_reg, hdr_err_reg;
  logic                         quat_valid_reg, gyro_valid_reg;
  logic [15:0]                  pkt_count_reg, err_count_reg;
  logic [NUM_WORDS-1:0][15:0]   fields;
  logic                         run, tick, rise_stb, fall_stb, end_stb, hdr_ok, accept, start;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .sck      (sck),
    .tick     (tick),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // SETUP is the leading low half-period; the transfer ends when the low half after the
  // 128th falling edge expires, so sck is stopped before it can rise a 129th time.
  assign end_stb = (state_reg == ST_SHIFT) && last_low_reg && tick;
  assign run     = ((state_reg == ST_SETUP) || (state_reg == ST_SHIFT)) && !end_stb;
  assign hdr_ok  = (packet_byte(shift_reg, HDR_OFS) == HEADER_BYTE);
  assign accept  = end_stb && hdr_ok;
  assign start   = (state_reg == ST_IDLE) && (state_next == ST_SETUP);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (enable && done_sync_reg) state_next = ST_SETUP;
      ST_SETUP:    if (rise_stb) state_next = ST_SHIFT;
      ST_SHIFT:    if (end_stb) state_next = ST_ACK;
      ST_ACK:      if (ack_cnt_reg == 16'(LOAD_CYCLES - 1)) state_next = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!done_sync_reg) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_meta_reg  <= 1'b0;
      done_sync_reg  <= 1'b0;
      shift_reg      <= '0;
      bit_cnt_reg    <= 7'd0;
      last_low_reg   <= 1'b0;
      ack_cnt_reg    <= 16'd0;
      load_reg       <= 1'b0;
      pkt_valid_reg  <= 1'b0;
      hdr_err_reg    <= 1'b0;
      quat_valid_reg <= 1'b0;
      gyro_valid_reg <= 1'b0;
      pkt_count_reg  <= 16'd0;
      err_count_reg  <= 16'd0;
    end else begin
      done_meta_reg <= done;
      done_sync_reg <= done_meta_reg;
      if (start) begin
        shift_reg    <= '0;
        bit_cnt_reg  <= 7'd0;
        last_low_reg <= 1'b0;
      end
      if (rise_stb) begin
        shift_reg   <= {shift_reg[PACKET_BITS-2:0], sdi};
        bit_cnt_reg <= bit_cnt_reg + 7'd1;
      end
      // The 7-bit counter has wrapped back to 0 only after the 128th rising edge
      if (fall_stb && (bit_cnt_reg == 7'd0)) last_low_reg <= 1'b1;
      ack_cnt_reg   <= (state_reg == ST_ACK) ? ack_cnt_reg + 16'd1 : 16'd0;
      load_reg      <= (state_next == ST_ACK);
      pkt_valid_reg <= accept;
      hdr_err_reg   <= end_stb && !hdr_ok;
      if (accept) begin
        quat_valid_reg <= shift_reg[FLAG_QUAT_VALID];
        gyro_valid_reg <= shift_reg[FLAG_GYRO_VALID];
        pkt_count_reg  <= pkt_count_reg + 16'd1;
      end
      if (end_stb && !hdr_ok && (err_count_reg != 16'hFFFF)) err_count_reg <= err_count_reg + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_field
    logic [15:0] field_reg;
    always_ff @(posedge clk) begin
      if (!rst_n)      field_reg <= 16'd0;
      else if (accept) field_reg <= packet_word(shift_reg, WORD_OFS[gi]);
    end
    assign fields[gi] = field_reg;
  end

  assign quat_w     = fields[0];
  assign quat_x     = fields[1];
  assign quat_y     = fields[2];
  assign quat_z     = fields[3];
  assign gyro_x     = fields[4];
  assign gyro_y     = fields[5];
  assign gyro_z     = fields[6];
  assign quat_valid = quat_valid_reg;
  assign gyro_valid = gyro_valid_reg;
  assign load       = load_reg;
  assign pkt_valid  = pkt_valid_reg;
  assign hdr_err    = hdr_err_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign pkt_count  = pkt_count_reg;
  assign err_count  = err_count_reg;
  assign sdo        = 1'b0;

endmodule

// File: tb/tb_sensor_packet_spi_master.sv
// Directed bench: three readers (CLK_DIV 4/2/7) each fed by a mode-0 slave model sharing one packet image.
module tb_sensor_packet_spi_master;

  localparam int DIVS [3] = '{4, 2, 7};
  localparam logic [127:0] PKT_A   = 128'hAA40_0000_0000_0000_00FF_FE00_1080_0003;
  localparam logic [127:0] PKT_B   = 128'hAA12_34FE_DC7F_FF80_0100_05FF_FB12_34FE;
  localparam logic [127:0] PKT_BAD = 128'h5511_2233_4455_6677_8899_AABB_CCDD_EE01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable, done_a, done_b;
  logic [127:0] tx_bits = '0;
  int base [3] = '{0, 0, 0};
  int n_tests = 0;
  int n_fail  = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic load, sck, sdo, sdi, quat_valid, gyro_valid, pkt_valid, hdr_err, busy;
    logic signed [15:0] quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z;
    logic [15:0] pkt_count, err_count;
    int  fall_cnt = 0;
    int  rise_cnt = 0;
    int  period = 0;
    time last_rise = 0;
    int  idx;

    always @(negedge sck) fall_cnt++;
    always @(posedge sck) begin
      rise_cnt++;
      period = int'(($time - last_rise) / 10);
      last_rise = $time;
    end
    // Slave presents the MSB while sck is low and advances on every falling edge
    always_comb begin
      idx = fall_cnt - base[gi];
      if (idx >= 0 && idx < 128) sdi = tx_bits[7'(127 - idx)];
      else                       sdi = 1'b0;
    end

    sensor_packet_spi_master #(.CLK_DIV(DIVS[gi]), .LOAD_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .done(gi == 0 ? done_a : done_b),
      .load(load), .sck(sck), .sdo(sdo), .sdi(sdi),
      .quat_w(quat_w), .quat_x(quat_x), .quat_y(quat_y), .quat_z(quat_z),
      .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
      .quat_valid(quat_valid), .gyro_valid(gyro_valid), .pkt_valid(pkt_valid),
      .hdr_err(hdr_err), .busy(busy), .pkt_count(pkt_count), .err_count(err_count)
    );
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic publish(input logic [127:0] p);
    tx_bits = p;
    base[0] = g_dut[0].fall_cnt;
    base[1] = g_dut[1].fall_cnt;
    base[2] = g_dut[2].fall_cnt;
  endtask

  // Returns at the negedge of the first ACK cycle of reader 0
  task automatic wait_accept(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (g_dut[0].pkt_valid || g_dut[0].hdr_err) seen = 1'b1;
    end
    check("accept_timeout", 16'(seen), 16'd1);
  endtask

  task automatic drop_done_a();
    done_a = 1'b0;
    step(4);
    check("idle_after_done_low", 16'(g_dut[0].busy), 16'd0);
  endtask

  initial begin
    int r0, r1, r2;
    bit seen;

    rst_n = 1'b0; enable = 1'b0; done_a = 1'b0; done_b = 1'b0;
    step(3);
    check("rst_sck",       16'(g_dut[0].sck),       16'd0);
    check("rst_busy",      16'(g_dut[0].busy),      16'd0);
    check("rst_load",      16'(g_dut[0].load),      16'd0);
    check("rst_sdo",       16'(g_dut[0].sdo),       16'd0);
    check("rst_pkt_count", g_dut[0].pkt_count,      16'd0);
    check("rst_err_count", g_dut[0].err_count,      16'd0);
    check("rst_quat_w",    g_dut[0].quat_w,         16'd0);
    rst_n = 1'b1;
    step(2);

    // CLK_DIV 2 and 7 readers run concurrently
    publish(PKT_A);
    enable = 1'b1;
    r1 = g_dut[1].rise_cnt;
    r2 = g_dut[2].rise_cnt;
    done_b = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (g_dut[2].pkt_count == 16'd1) seen = 1'b1;
    end
    check("div7_timeout",    16'(seen),                      16'd1);
    check("div2_pkt_count",  g_dut[1].pkt_count,             16'd1);
    check("div2_rises",      16'(g_dut[1].rise_cnt - r1),    16'd128);
    check("div7_rises",      16'(g_dut[2].rise_cnt - r2),    16'd128);
    check("div2_period",     16'(g_dut[1].period),           16'd4);
    check("div7_period",     16'(g_dut[2].period),           16'd14);
    check("div2_gyro_z",     g_dut[1].gyro_z,                16'h8000);
    check("div7_quat_w",     g_dut[2].quat_w,                16'h4000);
    $display("[TB] div2/div7 packet: quat_w=%h/%h rises=%0d/%0d", g_dut[1].quat_w, g_dut[2].quat_w,
             g_dut[1].rise_cnt - r1, g_dut[2].rise_cnt - r2);
    done_b = 1'b0;
    step(6);

    // Reader 0, good packet, exact latency
    publish(PKT_A);
    r0 = g_dut[0].rise_cnt;
    done_a = 1'b1;
    step(2);
    check("busy_before_sync",  16'(g_dut[0].busy),      16'd0);
    step(1);
    check("busy_setup_entry",  16'(g_dut[0].busy),      16'd1);
    step(1027);
    check("pkt_valid_early",   16'(g_dut[0].pkt_valid), 16'd0);
    step(1);
    check("pkt_valid_c1028",   16'(g_dut[0].pkt_valid), 16'd1);
    check("load_first",        16'(g_dut[0].load),      16'd1);
    check("hdr_err_good",      16'(g_dut[0].hdr_err),   16'd0);
    check("a_quat_w",          g_dut[0].quat_w,         16'h4000);
    check("a_quat_x",          g_dut[0].quat_x,         16'h0000);
    check("a_gyro_x",          g_dut[0].gyro_x,         16'hFFFE);
    check("a_gyro_y",          g_dut[0].gyro_y,         16'h0010);
    check("a_gyro_z",          g_dut[0].gyro_z,         16'h8000);
    check("a_quat_valid",      16'(g_dut[0].quat_valid),16'd1);
    check("a_gyro_valid",      16'(g_dut[0].gyro_valid),16'd1);
    check("a_pkt_count",       g_dut[0].pkt_count,      16'd1);
    $display("[TB] pkt A: quat_w=%h gyro=%h/%h/%h count=%0d", g_dut[0].quat_w, g_dut[0].gyro_x,
             g_dut[0].gyro_y, g_dut[0].gyro_z, g_dut[0].pkt_count);
    step(1);
    check("load_second",       16'(g_dut[0].load),      16'd1);
    check("pkt_valid_strobe",  16'(g_dut[0].pkt_valid), 16'd0);
    step(1);
    check("load_end",          16'(g_dut[0].load),      16'd0);
    check("a_rises",           16'(g_dut[0].rise_cnt - r0), 16'd128);

    // done held high: parked in WAIT_LOW, no second read
    step(50);
    check("wait_low_busy",     16'(g_dut[0].busy),      16'd1);
    check("wait_low_count",    g_dut[0].pkt_count,      16'd1);
    drop_done_a();

    publish(PKT_A);
    done_a = 1'b1;
    wait_accept(1100);
    check("second_pkt_valid",  16'(g_dut[0].pkt_valid), 16'd1);
    check("second_pkt_count",  g_dut[0].pkt_count,      16'd2);
    $display("[TB] pkt A again: count=%0d", g_dut[0].pkt_count);
    drop_done_a();

    // Bad header
    publish(PKT_BAD);
    done_a = 1'b1;
    wait_accept(1100);
    check("bad_hdr_err",       16'(g_dut[0].hdr_err),   16'd1);
    check("bad_pkt_valid",     16'(g_dut[0].pkt_valid), 16'd0);
    check("bad_load",          16'(g_dut[0].load),      16'd1);
    check("bad_err_count",     g_dut[0].err_count,      16'd1);
    check("bad_pkt_count",     g_dut[0].pkt_count,      16'd2);
    check("bad_quat_w_kept",   g_dut[0].quat_w,         16'h4000);
    check("bad_gyro_x_kept",   g_dut[0].gyro_x,         16'hFFFE);
    $display("[TB] pkt BAD: hdr_err=%0b err_count=%0d", g_dut[0].hdr_err, g_dut[0].err_count);
    step(1);
    check("bad_load_second",   16'(g_dut[0].load),      16'd1);
    drop_done_a();

    // Reset in the middle of the shift
    publish(PKT_B);
    r0 = g_dut[0].rise_cnt;
    done_a = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (g_dut[0].rise_cnt - r0 >= 60) seen = 1'b1;
    end
    check("bit60_timeout",     16'(seen),               16'd1);
    rst_n = 1'b0;
    done_a = 1'b0;
    step(1);
    check("mid_rst_sck",       16'(g_dut[0].sck),       16'd0);
    check("mid_rst_busy",      16'(g_dut[0].busy),      16'd0);
    check("mid_rst_load",      16'(g_dut[0].load),      16'd0);
    check("mid_rst_pkt_count", g_dut[0].pkt_count,      16'd0);
    check("mid_rst_err_count", g_dut[0].err_count,      16'd0);
    check("mid_rst_quat_w",    g_dut[0].quat_w,         16'd0);
    check("mid_rst_gyro_x",    g_dut[0].gyro_x,         16'd0);
    check("mid_rst_gyro_vld",  16'(g_dut[0].gyro_valid),16'd0);
    rst_n = 1'b1;
    step(2);
    publish(PKT_B);
    done_a = 1'b1;
    wait_accept(1100);
    check("b_pkt_valid",       16'(g_dut[0].pkt_valid), 16'd1);
    check("b_quat_w",          g_dut[0].quat_w,         16'h1234);
    check("b_quat_x",          g_dut[0].quat_x,         16'hFEDC);
    check("b_quat_y",          g_dut[0].quat_y,         16'h7FFF);
    check("b_quat_z",          g_dut[0].quat_z,         16'h8001);
    check("b_gyro_x",          g_dut[0].gyro_x,         16'h0005);
    check("b_gyro_y",          g_dut[0].gyro_y,         16'hFFFB);
    check("b_gyro_z",          g_dut[0].gyro_z,         16'h1234);
    check("b_quat_valid",      16'(g_dut[0].quat_valid),16'd0);
    check("b_gyro_valid",      16'(g_dut[0].gyro_valid),16'd1);
    check("b_pkt_count",       g_dut[0].pkt_count,      16'd1);
    $display("[TB] pkt B after reset: quat=%h %h %h %h count=%0d", g_dut[0].quat_w, g_dut[0].quat_x,
             g_dut[0].quat_y, g_dut[0].quat_z, g_dut[0].pkt_count);
    drop_done_a();

    // Counter boundaries
    force g_dut[0].dut.pkt_count_reg = 16'hFFFF;
    step(1);
    release g_dut[0].dut.pkt_count_reg;
    step(1);
    check("pkt_count_preset",  g_dut[0].pkt_count,      16'hFFFF);
    publish(PKT_A);
    done_a = 1'b1;
    wait_accept(1100);
    check("wrap_pkt_valid",    16'(g_dut[0].pkt_valid), 16'd1);
    check("pkt_count_wrap",    g_dut[0].pkt_count,      16'd0);
    $display("[TB] pkt A at wrap: count=%0d", g_dut[0].pkt_count);
    drop_done_a();

    force g_dut[0].dut.err_count_reg = 16'hFFFF;
    step(1);
    release g_dut[0].dut.err_count_reg;
    step(1);
    check("err_count_preset",  g_dut[0].err_count,      16'hFFFF);
    publish(PKT_BAD);
    done_a = 1'b1;
    wait_accept(1100);
    check("sat_hdr_err",       16'(g_dut[0].hdr_err),   16'd1);
    check("err_count_sat",     g_dut[0].err_count,      16'hFFFF);
    check("sat_pkt_count",     g_dut[0].pkt_count,      16'd0);
    $display("[TB] pkt BAD at saturation: err_count=%h", g_dut[0].err_count);
    drop_done_a();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
